// File: rtl/sblk_inst_disp.sv
// Superblock instruction dispatcher: accepts one instruction at a time, waits for its
// target rows to go idle, strobes it onto the selected row lanes, then holds off for a guard window.
module sblk_inst_disp #(
  parameter int unsigned N_ROW     = 7,
  parameter int unsigned WID_INST  = 14,
  parameter int unsigned GUARD_CYC = 2,
  parameter int unsigned WID_CNT   = 16
) (
  input  logic                      clk_l,
  input  logic                      rst_n,
  input  logic [WID_INST-1:0]       s_inst_data,
  input  logic [N_ROW-1:0]          s_row_mask,
  input  logic                      s_vld,
  output logic                      s_rdy,
  output logic [WID_INST*N_ROW-1:0] inst_data,
  output logic [N_ROW-1:0]          inst_en,
  input  logic [N_ROW-1:0]          status_sblk,
  output logic                      all_idle,
  output logic [WID_CNT-1:0]        issue_cnt,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned LANE_W = WID_INST * N_ROW;
  localparam int unsigned GCW    = 4;
  localparam logic [GCW-1:0] GUARD_LD = GCW'(GUARD_CYC - 1);
  localparam logic [7:0]     DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WID_INST-1:0] word_q,  word_d;
  logic [N_ROW-1:0]    mask_q,  mask_d;
  logic [GCW-1:0]      gcnt_q,  gcnt_d;
  logic [N_ROW-1:0]    en_q,    en_d;
  logic [LANE_W-1:0]   data_q,  data_d;
  logic [WID_CNT-1:0]  icnt_q,  icnt_d;
  logic [7:0]          dcnt_q,  dcnt_d;

  // State and datapath registers
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      mask_q  <= '0;
      gcnt_q  <= '0;
      en_q    <= '0;
      data_q  <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      gcnt_q  <= gcnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state and output decode; the strobe and lanes update together on the ISSUE edge
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    gcnt_d  = gcnt_q;
    en_d    = '0;
    data_d  = data_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (s_vld) begin
          if (|s_row_mask) begin
            word_d  = s_inst_data;
            mask_d  = s_row_mask;
            state_d = ST_WAIT;
          end else if (dcnt_q != DROP_MAX) begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
      end
      ST_WAIT: begin
        if ((status_sblk & mask_q) == '0) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        en_d = mask_q;
        for (int i = 0; i < int'(N_ROW); i++) begin
          if (mask_q[i]) data_d[i*WID_INST +: WID_INST] = word_q;
        end
        icnt_d  = icnt_q + WID_CNT'(1);
        gcnt_d  = GUARD_LD;
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if (gcnt_q == '0) state_d = ST_IDLE;
        else              gcnt_d  = gcnt_q - GCW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_rdy     = (state_q == ST_IDLE);
  assign all_idle  = (state_q == ST_IDLE) & ~|status_sblk;
  assign inst_en   = en_q;
  assign inst_data = data_q;
  assign issue_cnt = icnt_q;
  assign drop_cnt  = dcnt_q;

endmodule

// File: doc/sblk_inst_disp.md
SBLK_INST_DISP -- requirements
Module: sblk_inst_disp

Interface
REQ-001 Parameter N_ROW, default 7: number of superblock rows served.
REQ-002 Parameter WID_INST, default 14: instruction word width (TN+TM+TP+LN+LP fields).
REQ-003 Parameter GUARD_CYC, default 2: post-issue hold-off cycles, legal range 1..15.
REQ-004 Parameter WID_CNT, default 16: issued-instruction counter width.
REQ-005 The block SHALL have port clk_l, input, 1: single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port s_inst_data, input, WID_INST: upstream instruction word.
REQ-008 The block SHALL have port s_row_mask, input, N_ROW: target rows, bit i selects row i.
REQ-009 The block SHALL have port s_vld, input, 1: upstream instruction valid.
REQ-010 The block SHALL have port s_rdy, output, 1: dispatcher ready to accept.
REQ-011 The block SHALL have port inst_data, output, WID_INST*N_ROW: per-row instruction lanes, row i at [i*WID_INST +: WID_INST].
REQ-012 The block SHALL have port inst_en, output, N_ROW: per-row one-cycle instruction strobe.
REQ-013 The block SHALL have port status_sblk, input, N_ROW: per-row busy flag, 1 = busy.
REQ-014 The block SHALL have port all_idle, output, 1: dispatcher in IDLE and status_sblk == 0.
REQ-015 The block SHALL have port issue_cnt, output, WID_CNT: count of issued instructions.
REQ-016 The block SHALL have port drop_cnt, output, 8: count of zero-mask instructions dropped.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, ISSUE and GUARD, all registered.
REQ-018 In IDLE, s_rdy SHALL be 1; in every other state s_rdy SHALL be 0.
REQ-019 On IDLE with s_vld=1 and s_row_mask!=0, the block SHALL capture the word and mask and go to WAIT.
REQ-020 On IDLE with s_vld=1 and s_row_mask==0, the block SHALL consume the word, increment drop_cnt (saturating at 255), and stay in IDLE.
REQ-021 In WAIT, when (status_sblk & captured mask)==0, the block SHALL go to ISSUE; otherwise it SHALL stay in WAIT indefinitely. Unmasked rows' status SHALL be ignored.
REQ-022 In ISSUE (exactly one cycle), inst_en SHALL equal the captured mask, registered.
REQ-023 In ISSUE, inst_data lanes of masked rows SHALL carry the captured word; unmasked lanes SHALL hold their previous value.
REQ-024 In ISSUE, issue_cnt SHALL increment by 1, wrapping modulo 2^WID_CNT; the block SHALL then go to GUARD.
REQ-025 GUARD SHALL last exactly GUARD_CYC cycles, driven by a down-counter, then the block SHALL return to IDLE.
REQ-026 In every state other than ISSUE, inst_en SHALL be 0.
REQ-027 Minimum latency SHALL be: handshake on edge t -> WAIT at t+1 -> inst_en high during the cycle after edge t+2 (rows idle); next s_rdy after GUARD_CYC further cycles.
REQ-028 Throughput SHALL be at most one instruction per 3+GUARD_CYC cycles.
REQ-029 Lane i SHALL be written only on a cycle where inst_en[i]=1.
REQ-030 A status_sblk change during ISSUE or GUARD SHALL have no effect on the current dispatch.
REQ-031 all_idle SHALL be combinational: (state==IDLE) & ~|status_sblk.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, inst_en=0, inst_data=0, issue_cnt=0, drop_cnt=0, captured word/mask=0, guard counter=0.
REQ-033 During reset s_rdy SHALL be 1, per the IDLE rule.
REQ-034 Reset asserted in WAIT, ISSUE or GUARD SHALL discard the pending instruction with no inst_en pulse after reset.
REQ-035 The first handshake SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-036 Bench SHALL cover: status=0, send word 0x1A5 with mask 7'b0000101 -> inst_en=0000101 for exactly 1 cycle, 2 cycles after the handshake; lanes 0 and 2 = 0x1A5, others 0; issue_cnt=1.
REQ-037 Bench SHALL cover: status[2]=1, send mask 0000100 -> inst_en stays 0 for 10 cycles; release status[2] -> inst_en=0000100 one cycle after the WAIT evaluation.
REQ-038 Bench SHALL cover: status[5]=1 held, send mask 0000011 -> issue not blocked; inst_en=0000011.
REQ-039 Bench SHALL cover: s_vld with mask 0 -> s_rdy stays 1, drop_cnt=1, no inst_en; 300 such words -> drop_cnt=255.
REQ-040 Bench SHALL cover: back-to-back s_vld with GUARD_CYC=2 -> inst_en pulses spaced exactly 5 cycles apart; issue_cnt at 0xFFFF wraps to 0.
REQ-041 Bench SHALL cover: rst_n pulsed low while in WAIT -> all outputs are reset values immediately, and no inst_en pulse occurs after release.
